dspl_scan_rx: RTL and testbench

DSPL_SCAN_RX -- requirements
Module: dspl_scan_rx

---
 rtl/dspl_scan_rx.sv | 123 ++++++++++++
 tb/tb_dspl_scan_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dspl_scan_rx.sv
// dspl_scan_rx: recovers eight digits from a multiplexed 7-segment scan bus.
// Samples are debounced before decode, and positions not refreshed in time blank out.
module dspl_scan_rx #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] seg,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       upd,
    output logic       err
);
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
    localparam logic [31:0] AGE_MAX = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t        r_state, w_state_next;
    logic [15:0]   r_sync, r_s, r_s_prev;
    logic [CW-1:0] r_cnt;
    logic [5:0]    r_d [8];
    logic [31:0]   r_age [8];
    logic [5:0]    w_d_next [8];
    logic          r_chg, r_upd, r_err;
    logic [4:0]    w_code;
    logic          w_valid, w_chg, w_eval, w_one, w_multi, w_cap, w_err, w_any;

    always_comb begin
        w_code  = 5'h00;
        w_valid = 1'b1;
        case (r_s[7:1])
            7'b0000001: w_code = 5'h00;
            7'b1001111: w_code = 5'h01;
            7'b0010010: w_code = 5'h02;
            7'b0000110: w_code = 5'h03;
            7'b1001100: w_code = 5'h04;
            7'b0100100: w_code = 5'h05;
            7'b0100000: w_code = 5'h06;
            7'b0001111: w_code = 5'h07;
            7'b0000000: w_code = 5'h08;
            7'b0000100: w_code = 5'h09;
            7'b0011000: w_code = 5'h0A;
            7'b1100000: w_code = 5'h0B;
            7'b0110001: w_code = 5'h0C;
            7'b0110000: w_code = 5'h0E;
            7'b1000001: w_code = 5'h0F;
            7'b1111010: w_code = 5'h10;
            default:    w_valid = 1'b0;
        endcase
    end

    assign w_chg   = r_s != r_s_prev;
    assign w_eval  = (r_state == SETTLE) && !w_chg && (r_cnt == CNT_MAX);
    assign w_one   = $onehot(~r_s[15:8]);
    assign w_multi = !w_one && !(&r_s[15:8]);
    assign w_cap   = w_eval && w_one && w_valid;
    // One registered err per evaluation, however many causes apply.
    assign w_err   = w_eval && (w_multi || (w_one && (!w_valid || (r_s[0] != w_code[0]))));

    assign w_state_next = w_chg ? SETTLE : w_eval ? HELD : r_state;

    // Capture takes priority over the timeout blanking of the same position.
    always_comb begin
        w_any = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w_d_next[i] = (w_cap && !r_s[8+i]) ? {1'b1, w_code} :
                          (r_age[i] == AGE_MAX) ? {1'b0, r_d[i][4:0]} : r_d[i];
            w_any = w_any | (w_d_next[i] != r_d[i]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync   <= '1;
            r_s      <= '1;
            r_s_prev <= '1;
            r_cnt    <= '0;
            r_state  <= IDLE;
            r_chg    <= 1'b0;
            r_upd    <= 1'b0;
            r_err    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_d[i]   <= '0;
                r_age[i] <= '0;
            end
        end else begin
            r_sync   <= {an, seg};
            r_s      <= r_sync;
            r_s_prev <= r_s;
            r_cnt    <= w_chg ? '0 : (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            r_state  <= w_state_next;
            r_chg    <= w_any;
            r_upd    <= r_chg;
            r_err    <= w_err;
            for (int i = 0; i < 8; i++) begin
                r_d[i]   <= w_d_next[i];
                r_age[i] <= (w_cap && !r_s[8+i]) ? '0 :
                            (r_age[i] == AGE_MAX) ? r_age[i] : r_age[i] + 32'd1;
            end
        end
    end

    assign d1  = r_d[0];
    assign d2  = r_d[1];
    assign d3  = r_d[2];
    assign d4  = r_d[3];
    assign d5  = r_d[4];
    assign d6  = r_d[5];
    assign d7  = r_d[6];
    assign d8  = r_d[7];
    assign upd = r_upd;
    assign err = r_err;
endmodule

// File: tb/tb_dspl_scan_rx.sv
// tb_dspl_scan_rx: directed and randomized scan traffic for dspl_scan_rx,
// compared every cycle against a run-length / elapsed-time reference model.
module tb_dspl_scan_rx;
    localparam int S = 16;
    localparam int T = 100;
    localparam logic [6:0] GL [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100, 7'b0011000, 7'b1100000,
                                       7'b0110001, 7'b0110000, 7'b1000001, 7'b1111010};
    localparam logic [4:0] CD [16] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                       5'h08, 5'h09, 5'h0A, 5'h0B, 5'h0C, 5'h0E, 5'h0F, 5'h10};

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] an = 8'hFF;
    logic [7:0] seg = 8'hFF;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       upd, err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_err   = 0;

    logic [5:0]  md [8];
    longint      last [8];
    longint      cyc = 0;
    logic        m_upd = 1'b0, m_err = 1'b0, m_chg = 1'b0;
    logic [15:0] m_prev = 16'hFFFF;
    int          m_run = 0;
    logic [15:0] pv [2];
    int          pr [2];

    dspl_scan_rx #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .an(an), .seg(seg),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .upd(upd), .err(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] mpack();
        return {md[7], md[6], md[5], md[4], md[3], md[2], md[1], md[0]};
    endfunction

    // A pin value held for S+1 consecutive edges is evaluated two edges after that run length is reached.
    task automatic model_step();
        logic [15:0] x;
        logic [5:0]  old [8];
        bit          err_now, found;
        int          z, pos;
        logic [4:0]  code;
        cyc++;
        x = reset ? 16'hFFFF : {an, seg};
        m_run = (x == m_prev) ? m_run + 1 : 1;
        m_prev = x;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                md[i] = '0;
                last[i] = cyc;
            end
            pr[0] = 0; pr[1] = 0;
            m_upd = 0; m_err = 0; m_chg = 0;
        end else begin
            old = md;
            err_now = 0;
            if (pr[1] == S + 1) begin
                z = 0; pos = 0;
                for (int i = 0; i < 8; i++) if (!pv[1][8+i]) begin z++; pos = i; end
                if (z > 1) err_now = 1;
                else if (z == 1) begin
                    found = 0; code = '0;
                    for (int k = 0; k < 16; k++) if (GL[k] == pv[1][7:1]) begin found = 1; code = CD[k]; end
                    if (!found) err_now = 1;
                    else begin
                        if (pv[1][0] != code[0]) err_now = 1;
                        md[pos] = {1'b1, code};
                        last[pos] = cyc;
                    end
                end
            end
            for (int i = 0; i < 8; i++) if (cyc - last[i] >= T) md[i][5] = 1'b0;
            m_upd = m_chg;
            m_chg = 0;
            for (int i = 0; i < 8; i++) if (md[i] != old[i]) m_chg = 1;
            m_err = err_now;
            pv[1] = pv[0]; pr[1] = pr[0];
            pv[0] = x;     pr[0] = m_run;
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin md[i] = '0; last[i] = 0; end
        pv[0] = '1; pv[1] = '1; pr[0] = 0; pr[1] = 0;
        forever begin
            @(posedge clock);
            model_step();
            #1;
            check("d", {d8, d7, d6, d5, d4, d3, d2, d1}, mpack());
            check("upd", upd, m_upd);
            check("err", err, m_err);
            if (err) n_err++;
        end
    end

    task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
        an = a;
        seg = s;
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int e0, k, p, g;
        logic [7:0] s;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        hold(8'hFF, 8'hFF, 4);
        // Latency: first present edge plus S+2 more edges.
        an = 8'hFE; seg = 8'h00;
        repeat (S + 2) @(posedge clock);
        #1 check("d1_early", d1, 6'h00);
        @(posedge clock);
        #1 check("d1_lat", d1, 6'h28);
        check("err_028", err, 1'b0);
        @(posedge clock);
        #1 check("upd_028", upd, 1'b1);
        @(negedge clock);
        hold(8'hFE, 8'h00, 10);
        hold(8'hF7, 8'h02, 5);
        hold(8'hF7, 8'h9F, 2 * S + 8);
        check("d4_glitch", d4, 6'h21);
        e0 = n_err;
        hold(8'hBF, 8'hF4, 2 * S + 8);
        check("d7_r", d7, 6'h30);
        check("err_030a", n_err - e0, 0);
        hold(8'hBF, 8'hAA, 2 * S + 8);
        check("d7_keep", d7, 6'h30);
        check("err_030b", n_err - e0, 1);
        e0 = n_err;
        hold(8'hFC, 8'h02, 2 * S + 8);
        check("err_multi", n_err - e0, 1);
        hold(8'hFF, 8'hFF, 2 * S + 8);
        check("err_idle", n_err - e0, 1);
        hold(8'hFD, 8'h0D, S + 3);
        check("d2_cap", d2, 6'h23);
        hold(8'hFF, 8'hFF, 98);
        check("d2_alive", d2, 6'h23);
        hold(8'hFF, 8'hFF, 2);
        check("d2_tmo", d2, 6'h03);
        for (int r = 0; r < 3; r++) begin
            for (p = 0; p < 8; p++) begin
                k = $urandom_range(0, 15);
                s = {GL[k], CD[k][0] ^ ($urandom_range(0, 7) == 0)};
                g = $urandom_range(0, 9);
                if (g == 0) s = {7'b1010101, 1'b0};
                if (g == 1) hold(8'hFF ^ (8'h01 << p), {GL[$urandom_range(0, 15)], 1'b1}, $urandom_range(1, S - 2));
                if (g == 2) hold(8'h3C, s, 2 * S);
                if (r == 1 && p == 3) begin
                    hold(8'hFF ^ (8'h01 << p), s, S * 2);
                    reset = 1'b1;
                    #1 check("rst_d", {d8, d7, d6, d5, d4, d3, d2, d1}, 48'h0);
                    @(negedge clock);
                    hold(8'hFF ^ (8'h01 << p), s, 3);
                    reset = 1'b0;
                end
                hold(8'hFF ^ (8'h01 << p), s, S * 4);
            end
        end
        hold(8'hFF, 8'hFF, 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
